// File: rtl/ring_pkg.sv
// rtl/ring_pkg.sv - shared mode encoding for the ring/shift counter
package ring_pkg;

  typedef enum logic [1:0] {
    MODE_SHIFT   = 2'b00,
    MODE_RING    = 2'b01,
    MODE_JOHNSON = 2'b10,
    MODE_HOLD    = 2'b11
  } mode_t;

endpackage

// File: rtl/ring_state_check.sv
// rtl/ring_state_check.sv - legality and seed detection for a counter state
module ring_state_check
  import ring_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] s,
  input  logic [1:0]       mode,
  input  logic             dir,
  output logic             err,
  output logic             is_seed
);

  mode_t            m;
  logic [5:0]       trans_cnt;
  logic [WIDTH-1:0] ring_seed;

  assign m = mode_t'(mode);

  // A ring state must be one-hot; a Johnson state has at most one 0/1 boundary
  always_comb begin
    trans_cnt = '0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      trans_cnt = trans_cnt + 6'(s[i] ^ s[i+1]);
    end
    ring_seed = dir ? {{(WIDTH-1){1'b0}}, 1'b1} : {1'b1, {(WIDTH-1){1'b0}}};
    err     = 1'b0;
    is_seed = 1'b0;
    case (m)
      MODE_RING: begin
        err     = !$onehot(s);
        is_seed = (s == ring_seed);
      end
      MODE_JOHNSON: begin
        err     = (trans_cnt > 6'd1);
        is_seed = (s == '0);
      end
      default: begin
        err     = 1'b0;
        is_seed = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ring_shift_counter.sv
// rtl/ring_shift_counter.sv - configurable shift/ring/Johnson counter with load and self-correction
module ring_shift_counter
  import ring_pkg::*;
#(
  parameter int WIDTH    = 6,
  parameter bit AUTO_FIX = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             x,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] s,
  output logic             sout,
  output logic             wrap,
  output logic             err
);

  mode_t            m;
  logic             fb;
  logic             nb;
  logic             step;
  logic             fix;
  logic             seed_hit;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] seed;
  // Seed detection on the current state is not needed: wrap looks at the next state
  logic             unused_cur_is_seed;

  assign m = mode_t'(mode);

  ring_state_check #(
    .WIDTH (WIDTH)
  ) u_check (
    .s       (s),
    .mode    (mode),
    .dir     (dir),
    .err     (err),
    .is_seed (unused_cur_is_seed)
  );

  // Next-state candidate: bit leaving, bit entering, shifted value and the mode seed
  always_comb begin
    fb = dir ? s[WIDTH-1] : s[0];
    case (m)
      MODE_SHIFT:   nb = x;
      MODE_RING:    nb = fb;
      MODE_JOHNSON: nb = ~fb | x;
      default:      nb = fb;
    endcase
    shifted  = dir ? {s[WIDTH-2:0], nb} : {nb, s[WIDTH-1:1]};
    seed     = '0;
    if (m == MODE_RING) begin
      seed = dir ? {{(WIDTH-1){1'b0}}, 1'b1} : {1'b1, {(WIDTH-1){1'b0}}};
    end
    step     = en && (m != MODE_HOLD);
    // Force-one in Johnson mode deliberately builds states that may look illegal
    fix      = AUTO_FIX && err && !((m == MODE_JOHNSON) && x);
    seed_hit = ((m == MODE_RING) || (m == MODE_JOHNSON)) && (shifted == seed);
  end

  // State, serial-out and wrap registers: reset > load > step > hold
  always_ff @(posedge clk) begin
    if (reset) begin
      s    <= '0;
      sout <= 1'b0;
      wrap <= 1'b0;
    end else if (load) begin
      s    <= d;
      sout <= 1'b0;
      wrap <= 1'b0;
    end else if (step) begin
      if (fix) begin
        s    <= seed;
        sout <= 1'b0;
        wrap <= 1'b0;
      end else begin
        s    <= shifted;
        sout <= fb;
        wrap <= seed_hit;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ring_shift_counter.sv
// tb/tb_ring_shift_counter.sv - directed self-checking bench for ring_shift_counter
module tb_ring_shift_counter;

  logic       clk;
  logic       reset;
  logic       en;
  logic [1:0] mode;
  logic       dir;
  logic       x;
  logic       load;
  logic [5:0] d;
  logic [5:0] s;
  logic       sout;
  logic       wrap;
  logic       err;

  logic [5:0] ref_s;
  logic [1:0] ref_mode;
  logic       ref_dir;
  logic       ref_err;
  logic       ref_is_seed;

  int checks = 0;
  int errors = 0;

  logic [5:0] js [12];
  logic [5:0] rs [6];
  logic [5:0] ss [7];
  logic       sx [7];
  logic       so [7];

  ring_shift_counter #(
    .WIDTH    (6),
    .AUTO_FIX (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .mode  (mode),
    .dir   (dir),
    .x     (x),
    .load  (load),
    .d     (d),
    .s     (s),
    .sout  (sout),
    .wrap  (wrap),
    .err   (err)
  );

  ring_state_check #(
    .WIDTH (6)
  ) u_ref_check (
    .s       (ref_s),
    .mode    (ref_mode),
    .dir     (ref_dir),
    .err     (ref_err),
    .is_seed (ref_is_seed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    js = '{6'b100000, 6'b110000, 6'b111000, 6'b111100, 6'b111110, 6'b111111,
           6'b011111, 6'b001111, 6'b000111, 6'b000011, 6'b000001, 6'b000000};
    rs = '{6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b100000, 6'b000001};
    sx = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    ss = '{6'b100000, 6'b110000, 6'b011000, 6'b101100, 6'b010110, 6'b001011, 6'b000101};
    so = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    reset = 1'b1; en = 1'b0; mode = 2'b10; dir = 1'b0; x = 1'b0; load = 1'b0; d = '0;
    ref_s = '0; ref_mode = 2'b00; ref_dir = 1'b0;
    tick();
    tick();
    chk("reset_s", 32'(s), 32'h0);
    chk("reset_sout", 32'(sout), 32'h0);
    chk("reset_wrap", 32'(wrap), 32'h0);
    chk("reset_err_johnson", 32'(err), 32'h0);
    mode = 2'b01;
    #1;
    chk("reset_err_ring", 32'(err), 32'h1);
    mode = 2'b10;

    // Johnson count, 12 steps, wrap only on return to zero
    reset = 1'b0;
    en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk($sformatf("johnson_s_%0d", k), 32'(s), 32'(js[k]));
      chk($sformatf("johnson_wrap_%0d", k), 32'(wrap), (k == 11) ? 32'h1 : 32'h0);
      chk($sformatf("johnson_err_%0d", k), 32'(err), 32'h0);
    end
    en = 1'b0;
    tick();
    chk("en_low_freeze_s", 32'(s), 32'h0);
    chk("en_low_wrap_drop", 32'(wrap), 32'h0);

    // Ring with auto-seed from the illegal all-zero state, dir=1
    do_reset();
    mode = 2'b01;
    dir = 1'b1;
    en = 1'b1;
    #1;
    chk("ring_err_before_seed", 32'(err), 32'h1);
    tick();
    chk("ring_seed_s", 32'(s), 32'h01);
    chk("ring_seed_err", 32'(err), 32'h0);
    chk("ring_seed_wrap", 32'(wrap), 32'h0);
    chk("ring_seed_sout", 32'(sout), 32'h0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("ring_s_%0d", k), 32'(s), 32'(rs[k]));
      chk($sformatf("ring_wrap_%0d", k), 32'(wrap), (k == 5) ? 32'h1 : 32'h0);
    end
    chk("ring_sout_last", 32'(sout), 32'h1);

    // Serial shift toward LSB
    do_reset();
    mode = 2'b00;
    dir = 1'b0;
    for (int k = 0; k < 7; k++) begin
      x = sx[k];
      tick();
      chk($sformatf("shift_s_%0d", k), 32'(s), 32'(ss[k]));
      chk($sformatf("shift_sout_%0d", k), 32'(sout), 32'(so[k]));
      chk($sformatf("shift_wrap_%0d", k), 32'(wrap), 32'h0);
    end
    x = 1'b0;

    // Load beats enable; then the illegal ring state is replaced by the seed
    mode = 2'b01;
    dir = 1'b0;
    load = 1'b1;
    d = 6'b101010;
    tick();
    chk("load_s", 32'(s), 32'h2a);
    chk("load_sout", 32'(sout), 32'h0);
    chk("load_err_ring", 32'(err), 32'h1);
    load = 1'b0;
    tick();
    chk("load_fix_s", 32'(s), 32'h20);
    chk("load_fix_wrap", 32'(wrap), 32'h0);
    chk("load_fix_err", 32'(err), 32'h0);

    // Reset wins over load
    reset = 1'b1;
    load = 1'b1;
    d = 6'b111111;
    tick();
    chk("reset_over_load_s", 32'(s), 32'h0);
    reset = 1'b0;
    load = 1'b0;

    // Force-one in Johnson mode
    mode = 2'b10;
    x = 1'b1;
    tick();
    chk("force1_s_0", 32'(s), 32'h20);
    chk("force1_err_0", 32'(err), 32'h0);
    tick();
    chk("force1_s_1", 32'(s), 32'h30);
    tick();
    chk("force1_s_2", 32'(s), 32'h38);
    chk("force1_err_2", 32'(err), 32'h0);
    chk("force1_wrap_2", 32'(wrap), 32'h0);

    // Correction suppressed while x=1, applied once x drops
    load = 1'b1;
    d = 6'b101010;
    tick();
    load = 1'b0;
    chk("johnson_illegal_err", 32'(err), 32'h1);
    tick();
    chk("johnson_nofix_s", 32'(s), 32'h35);
    x = 1'b0;
    tick();
    chk("johnson_fix_s", 32'(s), 32'h0);
    chk("johnson_fix_wrap", 32'(wrap), 32'h0);
    chk("johnson_fix_sout", 32'(sout), 32'h0);

    // HOLD mode does not step
    mode = 2'b11;
    tick();
    chk("hold_s", 32'(s), 32'h0);
    chk("hold_err", 32'(err), 32'h0);

    // Reset in the middle of a Johnson count
    do_reset();
    mode = 2'b10;
    for (int k = 0; k < 7; k++) tick();
    chk("midrun_s_step7", 32'(s), 32'h1f);
    chk("midrun_sout_step7", 32'(sout), 32'h1);
    reset = 1'b1;
    tick();
    chk("midrun_reset_s", 32'(s), 32'h0);
    chk("midrun_reset_sout", 32'(sout), 32'h0);
    chk("midrun_reset_wrap", 32'(wrap), 32'h0);
    reset = 1'b0;
    tick();
    chk("midrun_resume_s", 32'(s), 32'h20);

    // Standalone legality checks on hand-picked states
    ref_s = 6'b000111; ref_mode = 2'b10; ref_dir = 1'b0;
    #1;
    chk("ref_johnson_legal", 32'(ref_err), 32'h0);
    ref_s = 6'b010000;
    #1;
    chk("ref_johnson_illegal", 32'(ref_err), 32'h1);
    ref_s = 6'b000100; ref_mode = 2'b01;
    #1;
    chk("ref_ring_legal", 32'(ref_err), 32'h0);
    ref_s = 6'b000110;
    #1;
    chk("ref_ring_illegal", 32'(ref_err), 32'h1);
    ref_s = 6'b000001; ref_dir = 1'b1;
    #1;
    chk("ref_ring_seed_dir1", 32'(ref_is_seed), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ring_shift_counter.md
# ring_shift_counter

Parametrised shift-register counter and successor to the fixed 6-bit twisted-ring counter. Width is configurable, direction is selectable, and one register supports four modes: serial shift, one-hot ring, twisted-ring (Johnson) and hold. It adds parallel load, illegal-state detection, optional self-correction and a wrap pulse. It sits in the sequencing and timing-generation layer, driving phase enables and acting as a serial-in converter.

## Interface
Parameters:
- WIDTH, default 6: register width; legal range 2..32.
- AUTO_FIX, default 1: when 1, illegal ring or Johnson states are replaced by the seed on the next step.

Ports:
- clk  in  1: single clock; all state updates on the rising edge.
- reset  in  1: synchronous, active-high; clears `s`, `wrap` and `sout`.
- en  in  1: step enable; when 0, state holds (load still acts).
- mode  in  2: 00 = SHIFT, 01 = RING, 10 = JOHNSON, 11 = HOLD.
- dir  in  1: 0 = shift toward LSB (new bit enters `s[WIDTH-1]`); 1 = shift toward MSB (new bit enters `s[0]`).
- x  in  1: serial input.
  - SHIFT: the data bit.
  - JOHNSON: force-one input.
  - RING: ignored.
- load  in  1: parallel load of `d`.
- d  in  WIDTH: load value.
- s  out  WIDTH: counter state, registered.
- sout  out  1: registered bit shifted out on the last step.
- wrap  out  1: registered one-cycle pulse when the seed state is re-entered by stepping.
- err  out  1: combinational; current `s` is illegal for the current mode.

## Operation
Definitions:
- fb = `s[0]` when dir=0, `s[WIDTH-1]` when dir=1. This is the bit leaving the register.
- Step: shift `s` one place in the `dir` direction; the vacated end receives `nb`.
- Priority per edge: reset > load > (en && mode≠HOLD) step > hold.

New bit `nb` per mode:
- SHIFT: `nb` = x.
- RING: `nb` = fb.
- JOHNSON: `nb` = ~fb | x. With x=0 and dir=0 this is the classic twisted ring.

Legality (drives `err`):
- SHIFT, HOLD: always legal; err=0.
- RING: legal iff `s` is exactly one-hot.
- JOHNSON: legal iff the count of adjacent-bit transitions `s[i]`≠`s[i+1]`, i = 0..WIDTH-2, is ≤1. No wrap-around pair is counted. This gives exactly 2·WIDTH legal states.

Seed values:
- RING: single 1 at `s[WIDTH-1]` when dir=0, at `s[0]` when dir=1.
- JOHNSON: all zeros.

Self-correction:
- Applies when AUTO_FIX=1, a step is taken, and err=1.
- `s` is loaded with the seed instead of the shifted value.
- sout = 0; wrap = 0.
- In JOHNSON mode, correction is suppressed while x=1, because force-one is intentional.

sout:
- Updated only on a step, to fb. This includes corrective steps, where it is 0.
- Cleared on load.

wrap:
- Asserted for one cycle when a normal, non-corrective step produces the seed of the current mode (RING or JOHNSON).
- Never asserted in SHIFT, on load, or on reset.

Mode change:
- Takes effect on the next step, with no flush.
- A now-illegal state is flagged and corrected as described above.

Width rules: all indices are modulo WIDTH only through the dir-selected shift; there is no arithmetic.

## Timing
- Latency: one cycle from an enabled edge to the updated `s`, `sout` and `wrap`. `err` follows `s` combinationally, in the same cycle.
- Reset values: s = 0, sout = 0, wrap = 0. err = 1 after reset if mode = RING, else 0.
- Period:
  - RING: wrap every WIDTH steps.
  - JOHNSON (x=0): wrap every 2·WIDTH steps.
- Simultaneous events:
  - load together with en: load wins, no step.
  - reset together with load: reset wins.
- Reset mid-sequence: state is lost, no wrap is emitted, and the sequence restarts from 0 on the next enabled edge.
- Toggling `en` low: freezes `s`; wrap deasserts the following cycle.
- dir change mid-sequence: the next step uses the new fb; no correction unless the state is illegal.

## Structure
- Shared package `ring_pkg`:
  - Mode constants: MODE_SHIFT, MODE_RING, MODE_JOHNSON, MODE_HOLD.
  - A 2-bit mode type.
- Sub-module `ring_state_check` (combinational): inputs s, mode; outputs err and is_seed(dir). It is instantiated once and reused by the bench as a reference checker.
- Main module: next-state mux and registers for s, sout, wrap.

## Test plan
- **Johnson count:** WIDTH=6, reset, mode=JOHNSON, dir=0, x=0, en=1, 12 steps.
  - `s` must step: 000000→100000→110000→…→111111→011111→…→000001→000000.
  - wrap is high exactly on the cycle `s` returns to 000000.
- **Ring auto-seed:** reset, then mode=RING, dir=1.
  - First step: 000000 is illegal, so `s` = 000001 and err drops to 0.
  - Next 6 steps: 000010, 000100, …, 100000, 000001, with wrap on the last.
- **Serial shift:** mode=SHIFT, dir=0, x sequence 1,1,0,1 from reset.
  - `s` = 100000, 110000, 011000, 101100.
  - sout stays 0 until the first 1 reaches `s[0]`.
- **Load priority:** load=1, en=1, d=6'b101010.
  - `s` = 101010, no shift.
  - RING mode: err=1; the next step loads the seed 100000 and wrap=0.
- **Force-one:** mode=JOHNSON, x=1 for 3 steps from 000000.
  - `s` = 100000, 110000, 111000.
  - No correction is applied.
  - err stays 0 for these legal states.
- **Reset mid-run:** assert reset at step 7 of a JOHNSON count.
  - Next cycle: s=0, wrap=0, sout=0.
  - The count resumes from 000000.
